button_conditioner: RTL

Front-end input stage for the Tetris board controller. It takes the four raw, asynchronous push-buttons, synchronises and debounces each one, and generates auto-repeat while a button is held. It feeds the position-shifter stage as a registered, one-hot, single-cycle `btn_pulse` bus. That stage acts on exact one-hot codes once per clock, so this block guarantees at most one bit set per cycle and exactly one pulse per press or repeat event.

---
 rtl/button_conditioner_if.sv | 19 +
 rtl/button_conditioner.sv | 107 ++++++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
// Button bus: raw push-button inputs plus the conditioned
// level and one-hot pulse outputs.
interface button_conditioner_if;
    logic [3:0] btn_raw;
    logic [3:0] btn_pulse;
    logic [3:0] btn_level;

    modport master (
        output btn_raw,
        input  btn_pulse,
        input  btn_level
    );

    modport slave (
        input  btn_raw,
        output btn_pulse,
        output btn_level
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronise, debounce and auto-repeat four push-buttons, then
// serialise their events onto a registered one-hot pulse bus.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input logic                 clk,
    input logic                 rst_n,
    button_conditioner_if.slave bus
);
    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                          ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_PERIOD)
                          ? MAX_AB : REPEAT_PERIOD;
    localparam int W = $clog2(MAX_P) + 1;

    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] DB_LAST = W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]   meta;
    logic [3:0]   sync;
    logic [3:0]   level_d;
    logic [3:0]   pend;
    logic [3:0]   press;
    logic [3:0]   rep;
    logic [3:0]   ev;
    logic [3:0]   grant;
    logic [W-1:0] cnt [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta          <= '0;
            sync          <= '0;
            level_d       <= '0;
            bus.btn_level <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            meta    <= bus.btn_raw;
            sync    <= meta;
            level_d <= bus.btn_level;
            for (int i = 0; i < 4; i++) begin
                if (sync[i] == bus.btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    cnt[i]           <= '0;
                    bus.btn_level[i] <= sync[i];
                end else begin
                    cnt[i] <= cnt[i] + ONE;
                end
            end
        end
    end

    // rep_q fires on the edge where hold would reach the delay,
    // so repeats line up with the press pipeline.
    if (REPEAT_DELAY != 0) begin : g_rep
        localparam logic [W-1:0] DLY = W'(REPEAT_DELAY);
        localparam logic [W-1:0] RLD = W'(REPEAT_DELAY - REPEAT_PERIOD);

        logic [W-1:0] hold [4];
        logic [3:0]   rep_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rep_q <= '0;
                for (int i = 0; i < 4; i++) begin
                    hold[i] <= '0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (!bus.btn_level[i]) begin
                        hold[i]  <= '0;
                        rep_q[i] <= 1'b0;
                    end else if (hold[i] + ONE == DLY) begin
                        hold[i]  <= RLD;
                        rep_q[i] <= 1'b1;
                    end else begin
                        hold[i]  <= hold[i] + ONE;
                        rep_q[i] <= 1'b0;
                    end
                end
            end
        end

        assign rep = rep_q & bus.btn_level;
    end else begin : g_norep
        assign rep = '0;
    end

    assign press = bus.btn_level & ~level_d;
    assign ev    = press | rep;
    assign grant = pend & (~pend + 4'd1);

    // A new event on the granted bit outranks its clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend          <= '0;
            bus.btn_pulse <= '0;
        end else begin
            bus.btn_pulse <= grant;
            pend          <= (pend & ~grant) | ev;
        end
    end
endmodule
